seg_scan_ctrl: RTL
==================

Name: seg_scan_ctrl

Overview:
Time-multiplexed scan controller that shares one BCD-to-7-segment decoder (SegDisplay) across NUM_DIGITS common-anode digits. It latches a 4-digit BCD word through a load handshake and applies it only at frame boundaries, so the display never tears. It sequences digit enables with a dead-time guard between digits and supports per-digit blanking and blinking. It sits between game/timer logic and the board display pins.

Parameters:
NUM_DIGITS, 4, number of scanned digits; fixed at 4 for this revision
REFRESH_DIV, 50000, clock cycles per digit slot, guard included; must be > GUARD_CYCLES
GUARD_CYCLES, 16, cycles at the start of each slot with all digits off (anti-ghosting)
BLINK_DIV, 25, full frames per blink half-period

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-low
load  in  1  request to accept load_value; single-cycle pulse or level
load_value  in  16  four BCD nibbles; [3:0]=digit0 (rightmost)
blank_mask  in  4  bit i=1 forces digit i off; sampled live
blink_mask  in  4  bit i=1 makes digit i blink; sampled live
load_pending  out  1  1 while an accepted value waits for the next frame boundary
seg_input  out  4  nibble to the shared decoder for the currently selected digit
digit_en  out  4  active-low digit enables; at most one bit low at any time
frame_done  out  1  one-cycle pulse on the last cycle of digit NUM_DIGITS-1's slot

Behaviour:
- Reset (rst=0 at a clk edge): state=GUARD, digit index=0, slot counter=0, frame counter=0, blink_phase=1 (visible), shadow=0, active=0, load_pending=0, seg_input=4'h0, digit_en=4'b1111, frame_done=0. Reset mid-frame discards any pending load.
- FSM has two states. GUARD lasts GUARD_CYCLES cycles with digit_en=4'b1111. DRIVE lasts REFRESH_DIV-GUARD_CYCLES cycles. DRIVE moves to GUARD of the next index; the index wraps from NUM_DIGITS-1 to 0.
- seg_input = active[4*idx+3:4*idx], registered, updated on entry to GUARD so it is stable before any enable goes low. Non-BCD nibbles pass through unchanged; the decoder shows its default pattern for them.
- In DRIVE, digit_en[idx]=0 unless blank_mask[idx]=1, or blink_mask[idx]=1 and blink_phase=0. All other bits are 1. blank_mask overrides blink.
- Load handshake: load=1 at a clk edge copies load_value into shadow and sets load_pending=1 on the next cycle. A later load while pending overwrites shadow; only the last one wins. There is no backpressure.
- Frame boundary is the cycle where frame_done=1. On that edge active<=shadow and load_pending<=0.
- If load=1 in the frame_done cycle, the new value bypasses shadow into active directly, and load_pending stays 0.
- Blink: the frame counter increments at each frame boundary. When it reaches BLINK_DIV-1 it wraps to 0 and blink_phase toggles.
- Counter widths are $clog2 of each divisor, minimum 1. Counters never exceed divisor-1.
- Digit-to-digit timing is exact: each digit is enabled for REFRESH_DIV-GUARD_CYCLES cycles per frame. Frame period is NUM_DIGITS*REFRESH_DIV cycles.

Decomposition:
- Shared package seg_pkg holds: state enum {GUARD, DRIVE}, DIGITS_OFF=4'b1111, NUM_DIGITS, BCD nibble width (4).
- One sub-module, seg_scan_tick: slot counter plus frame counter. It outputs slot_end, guard_end, frame_end and blink_phase.
- seg_scan_ctrl keeps the FSM, the shadow/active registers and the output muxing.
- The decoder is instantiated by the parent, not inside this block.

Test Plan (REFRESH_DIV=8, GUARD_CYCLES=2, BLINK_DIV=2):
- Reset then idle -> digit_en=4'b1111 for cycles 0-1. Then 4'b1110 for 6 cycles with seg_input=0, then guard, then 4'b1101. frame_done pulses every 32 cycles.
- Pulse load with 16'h1234 mid-frame -> load_pending=1 until frame_done. Next frame seg_input goes 4,3,2,1 for digits 0..3.
- Load 16'h1111 then 16'h5678 in the same frame -> only 5678 is displayed. load_pending clears at the boundary.
- load asserted exactly on the frame_done cycle with 16'h9999 -> next frame shows 9s and load_pending stays 0.
- blank_mask=4'b0100, blink_mask=4'b0001 -> digit2 is never enabled. Digit0 is enabled for 2 frames, disabled for 2 frames, repeating.
- rst low for 1 cycle during DRIVE of digit2 with a pending load -> outputs return to reset values next cycle and the pending value is lost.

Source files
------------

// File: rtl/seg_pkg.sv
// -----------------------------------------------------------------------------
// seg_pkg
// Shared definitions for the 7-segment scan controller: scan FSM states, the
// "all digits off" enable pattern, digit count, BCD nibble width and a helper
// that sizes counters from their divisors.
// -----------------------------------------------------------------------------
package seg_pkg;

  localparam int NUM_DIGITS = 4;
  localparam int BCD_W      = 4;

  // Common-anode enables are active-low, so all ones means every digit dark.
  localparam logic [NUM_DIGITS-1:0] DIGITS_OFF = '1;

  typedef enum logic {
    GUARD = 1'b0,
    DRIVE = 1'b1
  } scan_state_e;

  // Counter width for a divide-by-div counter; never narrower than one bit.
  function automatic int cnt_w(input int div);
    return (div > 1) ? $clog2(div) : 1;
  endfunction

endpackage

// File: rtl/seg_scan_tick.sv
// -----------------------------------------------------------------------------
// seg_scan_tick
// Timebase for the scan controller: a slot counter that splits every digit
// slot into a guard part and a drive part, plus a frame counter that derives
// the blink phase.
//
// Ports:
//   clk           system clock
//   rst           synchronous reset, active-low
//   last_digit_i  the slot currently running belongs to the last digit
//   slot_end_o    last cycle of the current digit slot
//   guard_end_o   last cycle of the guard part of the current slot
//   frame_end_o   last cycle of the last digit's slot (frame boundary)
//   blink_phase_o 1 = blinking digits visible, 0 = blinking digits dark
// -----------------------------------------------------------------------------
module seg_scan_tick
  import seg_pkg::*;
#(
  parameter int unsigned REFRESH_DIV  = 50000,
  parameter int unsigned GUARD_CYCLES = 16,
  parameter int unsigned BLINK_DIV    = 25
) (
  input  logic clk,
  input  logic rst,
  input  logic last_digit_i,
  output logic slot_end_o,
  output logic guard_end_o,
  output logic frame_end_o,
  output logic blink_phase_o
);

  localparam int SLOT_W  = cnt_w(REFRESH_DIV);
  localparam int FRAME_W = cnt_w(BLINK_DIV);

  localparam logic [SLOT_W-1:0]  SLOT_LAST  = SLOT_W'(REFRESH_DIV - 1);
  localparam logic [SLOT_W-1:0]  GUARD_LAST = SLOT_W'(GUARD_CYCLES - 1);
  localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(BLINK_DIV - 1);

  logic [SLOT_W-1:0]  slot_q, slot_d;
  logic [FRAME_W-1:0] frame_q, frame_d;
  logic               blink_q, blink_d;

  assign slot_end_o    = (slot_q == SLOT_LAST);
  assign guard_end_o   = (slot_q == GUARD_LAST);
  assign frame_end_o   = slot_end_o && last_digit_i;
  assign blink_phase_o = blink_q;

  // NOTE: every signal written here gets a default first, so no path through
  // the block leaves it unassigned and no latch is inferred.
  always_comb begin
    slot_d  = slot_end_o ? '0 : slot_q + 1'b1;
    frame_d = frame_q;
    blink_d = blink_q;
    if (frame_end_o) begin
      if (frame_q == FRAME_LAST) begin
        frame_d = '0;
        blink_d = ~blink_q;
      end else begin
        frame_d = frame_q + 1'b1;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      slot_q  <= '0;
      frame_q <= '0;
      blink_q <= 1'b1;
    end else begin
      slot_q  <= slot_d;
      frame_q <= frame_d;
      blink_q <= blink_d;
    end
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// -----------------------------------------------------------------------------
// seg_scan_ctrl
// Time-multiplexed scan controller sharing one BCD-to-7-segment decoder over
// four common-anode digits. A loaded BCD word is held in a shadow register
// and copied to the displayed (active) register only at frame boundaries, so
// a frame never shows a mix of old and new digits. Each digit slot starts with
// a dark guard interval before its enable is driven low.
//
// Ports:
//   clk          system clock
//   rst          synchronous reset, active-low
//   load         accept load_value this cycle (pulse or level)
//   load_value   four BCD nibbles, [3:0] = digit0 (rightmost)
//   blank_mask   bit i forces digit i dark (live)
//   blink_mask   bit i makes digit i blink (live)
//   load_pending an accepted value is waiting for the next frame boundary
//   seg_input    nibble for the shared decoder (currently selected digit)
//   digit_en     active-low digit enables, at most one low
//   frame_done   pulse on the last cycle of the last digit's slot
// -----------------------------------------------------------------------------
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int unsigned REFRESH_DIV  = 50000,
  parameter int unsigned GUARD_CYCLES = 16,
  parameter int unsigned BLINK_DIV    = 25
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          load,
  input  logic [NUM_DIGITS*BCD_W-1:0]   load_value,
  input  logic [NUM_DIGITS-1:0]         blank_mask,
  input  logic [NUM_DIGITS-1:0]         blink_mask,
  output logic                          load_pending,
  output logic [BCD_W-1:0]              seg_input,
  output logic [NUM_DIGITS-1:0]         digit_en,
  output logic                          frame_done
);

  localparam int IDX_W = cnt_w(NUM_DIGITS);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  scan_state_e                  state_q, state_d;
  logic [IDX_W-1:0]             idx_q, idx_d;
  logic [NUM_DIGITS*BCD_W-1:0]  shadow_q, shadow_d;
  logic [NUM_DIGITS*BCD_W-1:0]  active_q, active_d;
  logic                         pending_q, pending_d;
  logic [BCD_W-1:0]             seg_q, seg_d;

  logic slot_end, guard_end, frame_end, blink_phase;

  seg_scan_tick #(
    .REFRESH_DIV  (REFRESH_DIV),
    .GUARD_CYCLES (GUARD_CYCLES),
    .BLINK_DIV    (BLINK_DIV)
  ) u_tick (
    .clk           (clk),
    .rst           (rst),
    .last_digit_i  (idx_q == IDX_LAST),
    .slot_end_o    (slot_end),
    .guard_end_o   (guard_end),
    .frame_end_o   (frame_end),
    .blink_phase_o (blink_phase)
  );

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    shadow_d  = shadow_q;
    active_d  = active_q;
    pending_d = pending_q;
    seg_d     = seg_q;
    digit_en  = DIGITS_OFF;

    // Last load in a frame wins; shadow is always written so that the
    // unconditional shadow->active copy at later boundaries keeps it.
    if (load) begin
      shadow_d  = load_value;
      pending_d = 1'b1;
    end
    if (frame_end) begin
      active_d  = load ? load_value : shadow_q;
      pending_d = 1'b0;
    end

    case (state_q)
      GUARD: begin
        if (guard_end) state_d = DRIVE;
      end
      DRIVE: begin
        // Blanking wins over blinking.
        if (!(blank_mask[idx_q] || (blink_mask[idx_q] && !blink_phase))) begin
          digit_en[idx_q] = 1'b0;
        end
        if (slot_end) begin
          state_d = GUARD;
          idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
          // Nibble is taken from the post-boundary active word so the first
          // digit of a new frame already shows the new value.
          seg_d   = active_d[idx_d*BCD_W +: BCD_W];
        end
      end
      default: state_d = GUARD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= GUARD;
      idx_q     <= '0;
      shadow_q  <= '0;
      active_q  <= '0;
      pending_q <= 1'b0;
      seg_q     <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      shadow_q  <= shadow_d;
      active_q  <= active_d;
      pending_q <= pending_d;
      seg_q     <= seg_d;
    end
  end

  assign load_pending = pending_q;
  assign seg_input    = seg_q;
  assign frame_done   = frame_end;

endmodule
